fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the ID/EX forwarding logic for the 5-stage pipelined CPU.
- Keeps its own shadow of in-flight destinations (EX, MEM, WB) instead of taking them from the pipeline registers.
- Drives registered forward selects for NUM_SRC operands and detects load-use hazards, issuing stall/bubble.
- Honours memory freeze and branch flush; sits beside the ID stage and feeds the ID/EX operand muxes.

Parameters:
REG_AW, 3, register id width (GPR and special-register id spaces share this width)
NUM_SRC, 3, number of source operands checked per instruction (Rx, Ry, Rz)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds a real instruction
id_src_id  in  NUM_SRC*REG_AW  packed source ids; operand k at [k*REG_AW +: REG_AW]
id_src_rd  in  NUM_SRC  operand k is actually read
id_src_spec  in  NUM_SRC  operand k is a special register
id_wr_en  in  1  ID instruction writes a register
id_wr_id  in  REG_AW  its destination id
id_wr_spec  in  1  destination is a special register
id_is_load  in  1  ID instruction is a memory load
mem_busy  in  1  memory stage not ready; whole pipeline frozen
flush  in  1  squash instruction in ID (branch taken)
stall  out  1  hold PC and IF/ID
bubble  out  1  load NOP into ID/EX
fwd_sel  out  2*NUM_SRC  per operand: 00 regfile, 01 EX/MEM result, 10 MEM/WB result; registered

Behaviour:
- Shadow entries EX, MEM, WB each hold {v, wr_en, spec, id, ld}. Reset clears all v, fwd_sel=0.
- Match(entry, k): entry.v && entry.wr_en && id_src_rd[k] && entry.spec==id_src_spec[k] && entry.id==src id k. Full REG_AW compare for both spaces.
- hazard: id_valid && !flush && EX.ld && Match(EX,k) for any k.
- Combinational outputs: stall = hazard || mem_busy; bubble = hazard && !mem_busy.
- Per-cycle precedence, highest first:
  1. mem_busy=1: all state held, fwd_sel held. flush is ignored; the caller re-presents it after the freeze.
  2. flush=1: WB<=MEM, MEM<=EX, EX<=invalid, fwd_sel<=0.
  3. hazard=1: shift as for flush, EX<=invalid, fwd_sel<=0 (bubble). The ID instruction is re-evaluated next cycle; the load is then in MEM and selects 10.
  4. Otherwise: WB<=MEM, MEM<=EX, EX<={id_valid, id_wr_en, id_wr_spec, id_wr_id, id_is_load}.
- fwd_sel[k] per case 4 is computed from pre-shift state:
  - Match(EX,k) gives 01: the producer will be in EX/MEM when the consumer reaches EX.
  - Otherwise Match(MEM,k) gives 10.
  - Otherwise 00. The WB entry needs no forwarding because the regfile is write-first.
  - The younger producer (EX) always wins over MEM.
- The WB entry exists only for the perf counter and debug. It never affects fwd_sel.
- Latency: fwd_sel is valid the cycle the consumer sits in ID/EX, one clock after decode.
- Unread operands (id_src_rd[k]=0) always give 00. GPR vs special register with equal id never matches.
- Back-to-back loads to the same reg: each consumer stalls at most 1 cycle.
- Reset asserted mid-stall: stall/bubble drop immediately because shadow v=0.

Optional Feature:
- Macro FWD_HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt (32 b) and perf_fwd_cnt (32 b), async reset to 0.
  - perf_stall_cnt +1 per cycle with bubble=1.
  - perf_fwd_cnt +1 per case-4 cycle with any fwd_sel bit nonzero.
  - Both saturate at all-ones.
- Undefined: neither the ports nor the logic exist.

Decomposition:
- Shared package fwd_pkg: fwd_sel encodings FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10; the shadow entry struct/field widths.
- One sub-module, fwd_match: single operand-vs-entry comparator, instantiated NUM_SRC×2.

Test Plan:
- EX entry writes r3; ID reads Rx=r3 -> next cycle fwd_sel[1:0]=01, stall=0.
- EX writes r3 and MEM writes r3; ID reads Ry=r3 -> fwd_sel[3:2]=01 (younger wins). With only MEM writing r3 -> 10.
- EX is load to r5; ID reads r5 -> stall=1, bubble=1 for exactly 1 cycle, fwd_sel=0; next cycle fwd_sel=10, stall=0.
- Load-use hazard with mem_busy=1 for 3 cycles -> stall=1, bubble=0, shadow and fwd_sel frozen; after release -> 1 bubble cycle.
- Special-reg write id 0 in EX; ID reads GPR r0 -> 00. ID reads special id 0 -> 01.
- flush=1 with a matching load in EX -> no bubble, fwd_sel=0, EX invalid. With FWD_HAZARD_PERF_EN: 4 bubbles -> perf_stall_cnt=4.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared encodings for the ID-stage forwarding / load-use hazard unit.
package fwd_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Control half of a shadow entry; the id field is added by the user so it can follow REG_AW.
    typedef struct packed {
        logic v;
        logic wr_en;
        logic spec;
        logic ld;
    } shadow_ctrl_t;

    localparam int ENTRY_CTRL_W = $bits(shadow_ctrl_t);

    // The younger producer (EX) must win over MEM.
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit) return FWD_EXMEM;
        if (mem_hit) return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Compares one source operand against one shadow entry; GPR and special ids never alias.
module fwd_match #(
    parameter int REG_AW = 3
) (
    input  logic              ent_v,
    input  logic              ent_wr_en,
    input  logic              ent_spec,
    input  logic [REG_AW-1:0] ent_id,
    input  logic              src_rd,
    input  logic              src_spec,
    input  logic [REG_AW-1:0] src_id,
    output logic              hit
);

    assign hit = ent_v && ent_wr_en && src_rd && (ent_spec == src_spec) && (ent_id == src_id);

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding select and load-use hazard unit with its own EX/MEM/WB destination shadow.
// Optional saturating perf counters are built when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW  = 3,
    parameter int NUM_SRC = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]             id_src_id,
    input  logic [NUM_SRC-1:0]                    id_src_rd,
    input  logic [NUM_SRC-1:0]                    id_src_spec,
    input  logic                                  id_wr_en,
    input  logic [REG_AW-1:0]                     id_wr_id,
    input  logic                                  id_wr_spec,
    input  logic                                  id_is_load,
    input  logic                                  mem_busy,
    input  logic                                  flush,
    output logic                                  stall,
    output logic                                  bubble,
    output logic [2*NUM_SRC-1:0]                  fwd_sel,
    output logic [3*(ENTRY_CTRL_W+REG_AW)-1:0]    shadow_state
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]                           perf_stall_cnt,
    output logic [31:0]                           perf_fwd_cnt
`endif
);

    typedef struct packed {
        shadow_ctrl_t      ctrl;
        logic [REG_AW-1:0] id;
    } entry_t;

    entry_t               ex_q;
    entry_t               mem_q;
    entry_t               wb_q;
    entry_t               id_entry;
    logic [NUM_SRC-1:0]   ex_hit;
    logic [NUM_SRC-1:0]   mem_hit;
    logic [2*NUM_SRC-1:0] next_sel;
    logic                 hazard;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_match #(.REG_AW(REG_AW)) u_ex_match (
            .ent_v     (ex_q.ctrl.v),
            .ent_wr_en (ex_q.ctrl.wr_en),
            .ent_spec  (ex_q.ctrl.spec),
            .ent_id    (ex_q.id),
            .src_rd    (id_src_rd[k]),
            .src_spec  (id_src_spec[k]),
            .src_id    (id_src_id[k*REG_AW +: REG_AW]),
            .hit       (ex_hit[k])
        );
        fwd_match #(.REG_AW(REG_AW)) u_mem_match (
            .ent_v     (mem_q.ctrl.v),
            .ent_wr_en (mem_q.ctrl.wr_en),
            .ent_spec  (mem_q.ctrl.spec),
            .ent_id    (mem_q.id),
            .src_rd    (id_src_rd[k]),
            .src_spec  (id_src_spec[k]),
            .src_id    (id_src_id[k*REG_AW +: REG_AW]),
            .hit       (mem_hit[k])
        );
        assign next_sel[2*k +: 2] = fwd_pick(ex_hit[k], mem_hit[k]);
    end

    always_comb begin
        id_entry            = '0;
        id_entry.ctrl.v     = id_valid;
        id_entry.ctrl.wr_en = id_wr_en;
        id_entry.ctrl.spec  = id_wr_spec;
        id_entry.ctrl.ld    = id_is_load;
        id_entry.id         = id_wr_id;
    end

    // A load still in EX cannot forward yet; the consumer waits one cycle and then picks it up from MEM.
    assign hazard = id_valid && !flush && ex_q.ctrl.ld && (|ex_hit);
    assign stall  = hazard || mem_busy;
    assign bubble = hazard && !mem_busy;

    assign shadow_state = {wb_q, mem_q, ex_q};

    // mem_busy freezes everything, including a pending flush, which the caller re-presents later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_sel <= {NUM_SRC{FWD_RF}};
        end else if (!mem_busy) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (flush || hazard) begin
                ex_q    <= '0;
                fwd_sel <= {NUM_SRC{FWD_RF}};
            end else begin
                ex_q    <= id_entry;
                fwd_sel <= next_sel;
            end
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (bubble && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (!mem_busy && !flush && !hazard && (|next_sel) && (perf_fwd_cnt != '1))
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit (REG_AW=3, NUM_SRC=3); perf checks run when FWD_HAZARD_PERF_EN is defined.
module tb_fwd_hazard_unit;

    localparam int REG_AW  = 3;
    localparam int NUM_SRC = 3;
    localparam int EX_V    = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [8:0]  id_src_id = '0;
    logic [2:0]  id_src_rd = '0;
    logic [2:0]  id_src_spec = '0;
    logic        id_wr_en = 1'b0;
    logic [2:0]  id_wr_id = '0;
    logic        id_wr_spec = 1'b0;
    logic        id_is_load = 1'b0;
    logic        mem_busy = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic        bubble;
    logic [5:0]  fwd_sel;
    logic [20:0] shadow_state;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_fwd_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [5:0] exp_q[$];
    logic [1:0] ctl_q[$];

    typedef struct packed {
        logic       valid;
        logic [2:0] rd;
        logic [2:0] spec;
        logic [8:0] src;
        logic       wr_en;
        logic [2:0] wr_id;
        logic       wr_spec;
        logic       ld;
        logic       busy;
        logic       flush;
        logic       e_stall;
        logic       e_bubble;
        logic [5:0] e_sel;
        logic       chk_ex_inv;
    } vec_t;

    fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src_id    (id_src_id),
        .id_src_rd    (id_src_rd),
        .id_src_spec  (id_src_spec),
        .id_wr_en     (id_wr_en),
        .id_wr_id     (id_wr_id),
        .id_wr_spec   (id_wr_spec),
        .id_is_load   (id_is_load),
        .mem_busy     (mem_busy),
        .flush        (flush),
        .stall        (stall),
        .bubble       (bubble),
        .fwd_sel      (fwd_sel),
        .shadow_state (shadow_state)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Stimulus builders
    function automatic vec_t nop();
        vec_t v;
        v = '0;
        return v;
    endfunction

    function automatic vec_t wr(input logic [2:0] id, input logic sp);
        vec_t v;
        v = '0;
        v.valid   = 1'b1;
        v.wr_en   = 1'b1;
        v.wr_id   = id;
        v.wr_spec = sp;
        return v;
    endfunction

    function automatic vec_t ldr(input logic [2:0] id);
        vec_t v;
        v    = wr(id, 1'b0);
        v.ld = 1'b1;
        return v;
    endfunction

    function automatic vec_t rd(input vec_t vi, input int k, input logic [2:0] id, input logic sp);
        vec_t v;
        v = vi;
        v.valid          = 1'b1;
        v.rd[k]          = 1'b1;
        v.src[k*3 +: 3]  = id;
        v.spec[k]        = sp;
        return v;
    endfunction

    function automatic vec_t busy(input vec_t vi);
        vec_t v;
        v = vi;
        v.busy = 1'b1;
        return v;
    endfunction

    function automatic vec_t fl(input vec_t vi);
        vec_t v;
        v = vi;
        v.flush = 1'b1;
        return v;
    endfunction

    function automatic vec_t want(input vec_t vi, input logic s, input logic b, input logic [5:0] sel);
        vec_t v;
        v = vi;
        v.e_stall  = s;
        v.e_bubble = b;
        v.e_sel    = sel;
        return v;
    endfunction

    // Driver tasks
    task automatic drive_in(input vec_t v);
        id_valid    = v.valid;
        id_src_rd   = v.rd;
        id_src_spec = v.spec;
        id_src_id   = v.src;
        id_wr_en    = v.wr_en;
        id_wr_id    = v.wr_id;
        id_wr_spec  = v.wr_spec;
        id_is_load  = v.ld;
        mem_busy    = v.busy;
        flush       = v.flush;
    endtask

    task automatic apply(input vec_t v);
        drive_in(v);
        exp_q.push_back(v.e_sel);
        ctl_q.push_back({v.e_stall, v.e_bubble});
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_in(rd(ldr(3'd5), 0, 3'd5, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({stall, bubble, fwd_sel} !== 8'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b", {stall, bubble, fwd_sel}, 8'b0);
        end
        total++;
        if (shadow_state !== 21'd0) begin
            bad++;
            $display("FAIL reset_shadow got=%h exp=%h", shadow_state, 21'd0);
        end
        drive_in(nop());
        rst = 1'b1;
    endtask

    task automatic test_fwd_ex();
        vec_t seq[$];
        vec_t v;
        logic [1:0] ctl;
        logic [5:0] sel;
        repeat (3) seq.push_back(nop());
        seq.push_back(want(wr(3'd3, 1'b0), 1'b0, 1'b0, 6'b000000));
        seq.push_back(want(rd(nop(), 0, 3'd3, 1'b0), 1'b0, 1'b0, 6'b000001));
        seq.push_back(want(wr(3'd3, 1'b0), 1'b0, 1'b0, 6'b000000));
        seq.push_back(want(wr(3'd3, 1'b0), 1'b0, 1'b0, 6'b000000));
        seq.push_back(want(rd(nop(), 1, 3'd3, 1'b0), 1'b0, 1'b0, 6'b000100));
        seq.push_back(want(wr(3'd3, 1'b0), 1'b0, 1'b0, 6'b000000));
        seq.push_back(want(wr(3'd6, 1'b0), 1'b0, 1'b0, 6'b000000));
        // k0 carries id 3 but is unread; k1 hits MEM only; k2 hits EX
        v = rd(rd(nop(), 1, 3'd3, 1'b0), 2, 3'd6, 1'b0);
        v.src[2:0] = 3'd3;
        seq.push_back(want(v, 1'b0, 1'b0, 6'b011000));
        seq.push_back(nop());
        foreach (seq[i]) begin
            apply(seq[i]);
            #1;
            ctl = ctl_q.pop_front();
            total++;
            if ({stall, bubble} !== ctl) begin
                bad++;
                $display("FAIL fwd_ex stall_bubble row=%0d got=%b exp=%b", i, {stall, bubble}, ctl);
            end
            @(posedge clk);
            #1;
            sel = exp_q.pop_front();
            total++;
            if (fwd_sel !== sel) begin
                bad++;
                $display("FAIL fwd_ex fwd_sel row=%0d got=%b exp=%b", i, fwd_sel, sel);
            end
        end
    endtask

    task automatic test_load_use();
        vec_t seq[$];
        logic [1:0] ctl;
        logic [5:0] sel;
        repeat (3) seq.push_back(nop());
        seq.push_back(want(ldr(3'd5), 1'b0, 1'b0, 6'b000000));
        seq.push_back(want(rd(nop(), 0, 3'd5, 1'b0), 1'b1, 1'b1, 6'b000000));
        seq.push_back(want(rd(nop(), 0, 3'd5, 1'b0), 1'b0, 1'b0, 6'b000010));
        seq.push_back(nop());
        foreach (seq[i]) begin
            apply(seq[i]);
            #1;
            ctl = ctl_q.pop_front();
            total++;
            if ({stall, bubble} !== ctl) begin
                bad++;
                $display("FAIL load_use stall_bubble row=%0d got=%b exp=%b", i, {stall, bubble}, ctl);
            end
            @(posedge clk);
            #1;
            sel = exp_q.pop_front();
            total++;
            if (fwd_sel !== sel) begin
                bad++;
                $display("FAIL load_use fwd_sel row=%0d got=%b exp=%b", i, fwd_sel, sel);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t seq[$];
        logic [1:0] ctl;
        logic [5:0] sel;
        repeat (3) seq.push_back(nop());
        seq.push_back(want(ldr(3'd5), 1'b0, 1'b0, 6'b000000));
        seq.push_back(want(rd(ldr(3'd5), 0, 3'd5, 1'b0), 1'b1, 1'b1, 6'b000000));
        seq.push_back(want(rd(ldr(3'd5), 0, 3'd5, 1'b0), 1'b0, 1'b0, 6'b000010));
        seq.push_back(want(rd(nop(), 0, 3'd5, 1'b0), 1'b1, 1'b1, 6'b000000));
        seq.push_back(want(rd(nop(), 0, 3'd5, 1'b0), 1'b0, 1'b0, 6'b000010));
        seq.push_back(nop());
        foreach (seq[i]) begin
            apply(seq[i]);
            #1;
            ctl = ctl_q.pop_front();
            total++;
            if ({stall, bubble} !== ctl) begin
                bad++;
                $display("FAIL back_to_back stall_bubble row=%0d got=%b exp=%b", i, {stall, bubble}, ctl);
            end
            @(posedge clk);
            #1;
            sel = exp_q.pop_front();
            total++;
            if (fwd_sel !== sel) begin
                bad++;
                $display("FAIL back_to_back fwd_sel row=%0d got=%b exp=%b", i, fwd_sel, sel);
            end
        end
    endtask

    task automatic test_mem_busy();
        vec_t seq[$];
        logic [1:0] ctl;
        logic [5:0] sel;
        repeat (3) seq.push_back(nop());
        seq.push_back(want(wr(3'd2, 1'b0), 1'b0, 1'b0, 6'b000000));
        seq.push_back(want(rd(ldr(3'd5), 2, 3'd2, 1'b0), 1'b0, 1'b0, 6'b010000));
        seq.push_back(want(busy(rd(nop(), 0, 3'd5, 1'b0)), 1'b1, 1'b0, 6'b010000));
        seq.push_back(want(busy(rd(nop(), 0, 3'd5, 1'b0)), 1'b1, 1'b0, 6'b010000));
        seq.push_back(want(busy(fl(rd(nop(), 0, 3'd5, 1'b0))), 1'b1, 1'b0, 6'b010000));
        seq.push_back(want(rd(nop(), 0, 3'd5, 1'b0), 1'b1, 1'b1, 6'b000000));
        seq.push_back(want(rd(nop(), 0, 3'd5, 1'b0), 1'b0, 1'b0, 6'b000010));
        seq.push_back(nop());
        foreach (seq[i]) begin
            apply(seq[i]);
            #1;
            ctl = ctl_q.pop_front();
            total++;
            if ({stall, bubble} !== ctl) begin
                bad++;
                $display("FAIL mem_busy stall_bubble row=%0d got=%b exp=%b", i, {stall, bubble}, ctl);
            end
            @(posedge clk);
            #1;
            sel = exp_q.pop_front();
            total++;
            if (fwd_sel !== sel) begin
                bad++;
                $display("FAIL mem_busy fwd_sel row=%0d got=%b exp=%b", i, fwd_sel, sel);
            end
        end
    endtask

    task automatic test_spec();
        vec_t seq[$];
        logic [1:0] ctl;
        logic [5:0] sel;
        repeat (3) seq.push_back(nop());
        seq.push_back(want(wr(3'd0, 1'b1), 1'b0, 1'b0, 6'b000000));
        seq.push_back(want(rd(nop(), 0, 3'd0, 1'b0), 1'b0, 1'b0, 6'b000000));
        seq.push_back(want(wr(3'd0, 1'b1), 1'b0, 1'b0, 6'b000000));
        seq.push_back(want(rd(nop(), 0, 3'd0, 1'b1), 1'b0, 1'b0, 6'b000001));
        seq.push_back(want(wr(3'd0, 1'b0), 1'b0, 1'b0, 6'b000000));
        seq.push_back(want(rd(nop(), 1, 3'd0, 1'b1), 1'b0, 1'b0, 6'b000000));
        seq.push_back(nop());
        foreach (seq[i]) begin
            apply(seq[i]);
            #1;
            ctl = ctl_q.pop_front();
            total++;
            if ({stall, bubble} !== ctl) begin
                bad++;
                $display("FAIL spec stall_bubble row=%0d got=%b exp=%b", i, {stall, bubble}, ctl);
            end
            @(posedge clk);
            #1;
            sel = exp_q.pop_front();
            total++;
            if (fwd_sel !== sel) begin
                bad++;
                $display("FAIL spec fwd_sel row=%0d got=%b exp=%b", i, fwd_sel, sel);
            end
        end
    endtask

    task automatic test_flush();
        vec_t seq[$];
        vec_t v;
        logic [1:0] ctl;
        logic [5:0] sel;
        repeat (3) seq.push_back(nop());
        seq.push_back(want(ldr(3'd5), 1'b0, 1'b0, 6'b000000));
        v = want(fl(rd(nop(), 0, 3'd5, 1'b0)), 1'b0, 1'b0, 6'b000000);
        v.chk_ex_inv = 1'b1;
        seq.push_back(v);
        seq.push_back(want(rd(nop(), 0, 3'd5, 1'b0), 1'b0, 1'b0, 6'b000010));
        seq.push_back(want(wr(3'd4, 1'b0), 1'b0, 1'b0, 6'b000000));
        v = want(fl(rd(nop(), 0, 3'd4, 1'b0)), 1'b0, 1'b0, 6'b000000);
        v.chk_ex_inv = 1'b1;
        seq.push_back(v);
        seq.push_back(nop());
        foreach (seq[i]) begin
            apply(seq[i]);
            #1;
            ctl = ctl_q.pop_front();
            total++;
            if ({stall, bubble} !== ctl) begin
                bad++;
                $display("FAIL flush stall_bubble row=%0d got=%b exp=%b", i, {stall, bubble}, ctl);
            end
            @(posedge clk);
            #1;
            sel = exp_q.pop_front();
            total++;
            if (fwd_sel !== sel) begin
                bad++;
                $display("FAIL flush fwd_sel row=%0d got=%b exp=%b", i, fwd_sel, sel);
            end
            if (seq[i].chk_ex_inv) begin
                total++;
                if (shadow_state[EX_V] !== 1'b0) begin
                    bad++;
                    $display("FAIL flush ex_valid row=%0d got=%b exp=0", i, shadow_state[EX_V]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        drive_in(wr(3'd2, 1'b0));
        @(posedge clk);
        #1;
        drive_in(rd(ldr(3'd5), 1, 3'd2, 1'b0));
        @(posedge clk);
        #1;
        drive_in(rd(nop(), 0, 3'd5, 1'b0));
        #1;
        total++;
        if ({stall, bubble, fwd_sel} !== 8'b11_000100) begin
            bad++;
            $display("FAIL mid_stall_before got=%b exp=%b", {stall, bubble, fwd_sel}, 8'b11_000100);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({stall, bubble, fwd_sel} !== 8'b0) begin
            bad++;
            $display("FAIL mid_stall_reset got=%b exp=%b", {stall, bubble, fwd_sel}, 8'b0);
        end
        drive_in(nop());
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

`ifdef FWD_HAZARD_PERF_EN
    task automatic test_perf();
        vec_t seq[$];
        logic [1:0] ctl;
        logic [5:0] sel;
        rst = 1'b0;
        drive_in(nop());
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            seq.push_back(want(ldr(3'd5), 1'b0, 1'b0, 6'b000000));
            if (n == 3) seq.push_back(want(busy(rd(nop(), 0, 3'd5, 1'b0)), 1'b1, 1'b0, 6'b000000));
            seq.push_back(want(rd(nop(), 0, 3'd5, 1'b0), 1'b1, 1'b1, 6'b000000));
            seq.push_back(want(rd(nop(), 0, 3'd5, 1'b0), 1'b0, 1'b0, 6'b000010));
        end
        seq.push_back(nop());
        foreach (seq[i]) begin
            apply(seq[i]);
            #1;
            ctl = ctl_q.pop_front();
            total++;
            if ({stall, bubble} !== ctl) begin
                bad++;
                $display("FAIL perf stall_bubble row=%0d got=%b exp=%b", i, {stall, bubble}, ctl);
            end
            @(posedge clk);
            #1;
            sel = exp_q.pop_front();
            total++;
            if (fwd_sel !== sel) begin
                bad++;
                $display("FAIL perf fwd_sel row=%0d got=%b exp=%b", i, fwd_sel, sel);
            end
        end
        total++;
        if (perf_stall_cnt !== 32'd4) begin
            bad++;
            $display("FAIL perf_stall_cnt got=%0d exp=4", perf_stall_cnt);
        end
        total++;
        if (perf_fwd_cnt !== 32'd4) begin
            bad++;
            $display("FAIL perf_fwd_cnt got=%0d exp=4", perf_fwd_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fwd_ex();
        test_load_use();
        test_back_to_back();
        test_mem_busy();
        test_spec();
        test_flush();
        test_reset_mid_stall();
`ifdef FWD_HAZARD_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
